// File: rtl/csa_sub_pipe.sv
// Two-stage carry-select subtractor: diff = a - b - bin with borrow out, behind valid/ready.
// Optional signed-overflow output enabled by defining CSA_SUB_OVF_EN.
module csa_sub_pipe #(
  parameter int N    = 8,
  parameter int LO_W = N / 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bo
`ifdef CSA_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int HI_W = N - LO_W;

  // Zero-extended subtracts; the extra MSB of each result is the borrow.
  function automatic logic [LO_W:0] sub_lo(input logic [LO_W-1:0] x,
                                           input logic [LO_W-1:0] y,
                                           input logic            bi);
    return {1'b0, x} - {1'b0, y} - {{LO_W{1'b0}}, bi};
  endfunction

  function automatic logic [HI_W:0] sub_hi(input logic [HI_W-1:0] x,
                                           input logic [HI_W-1:0] y,
                                           input logic            bi);
    return {1'b0, x} - {1'b0, y} - {{HI_W{1'b0}}, bi};
  endfunction

  logic            en_p1, en_p2;
  logic            vld_p1, vld_p2;
  logic [LO_W:0]   lo_p1;
  logic [HI_W:0]   hi0_p1, hi1_p1;
  logic [HI_W:0]   hi_sel;
  logic [N-1:0]    diff_nxt;
  logic [N-1:0]    diff_p2;
  logic            bo_p2;

  assign en_p2    = ~vld_p2 | out_ready;
  assign en_p1    = ~vld_p1 | en_p2;
  assign in_ready = en_p1;

  // ---- stage 1: low-half subtract and both speculative high halves ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      lo_p1  <= '0;
      hi0_p1 <= '0;
      hi1_p1 <= '0;
    end else if (en_p1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        lo_p1  <= sub_lo(a[LO_W-1:0], b[LO_W-1:0], bin);
        hi0_p1 <= sub_hi(a[N-1:LO_W], b[N-1:LO_W], 1'b0);
        hi1_p1 <= sub_hi(a[N-1:LO_W], b[N-1:LO_W], 1'b1);
      end
    end
  end

  // ---- stage 2: low borrow selects the high half ----
  assign hi_sel   = lo_p1[LO_W] ? hi1_p1 : hi0_p1;
  assign diff_nxt = {hi_sel[HI_W-1:0], lo_p1[LO_W-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      diff_p2 <= '0;
      bo_p2   <= 1'b0;
    end else if (en_p2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        diff_p2 <= diff_nxt;
        bo_p2   <= hi_sel[HI_W];
      end
    end
  end

  assign out_valid = vld_p2;
  assign diff      = diff_p2;
  assign bo        = bo_p2;

`ifdef CSA_SUB_OVF_EN
  logic amsb_p1, bmsb_p1, ovf_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amsb_p1 <= 1'b0;
      bmsb_p1 <= 1'b0;
    end else if (en_p1 && in_valid) begin
      amsb_p1 <= a[N-1];
      bmsb_p1 <= b[N-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_p2 <= 1'b0;
    else if (en_p2 && vld_p1)
      ovf_p2 <= (amsb_p1 ^ bmsb_p1) & (amsb_p1 ^ diff_nxt[N-1]);
  end

  assign ovf = ovf_p2;
`endif

endmodule

// File: tb/tb_csa_sub_pipe.sv
// Directed bench for csa_sub_pipe: N=3 exhaustive stream plus N=8 vectors and handshake corners.
module tb_csa_sub_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // N=3, LO_W=1 instance
  logic       iv3, ir3, ov3, or3, bin3, bo3;
  logic [2:0] a3, b3, d3;
  // N=8 instance
  logic       iv8, ir8, ov8, or8, bin8, bo8;
  logic [7:0] a8, b8, d8;
`ifdef CSA_SUB_OVF_EN
  logic       ovf3, ovf8;
`endif

  csa_sub_pipe #(.N(3), .LO_W(1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .a(a3), .b(b3), .bin(bin3),
    .out_valid(ov3), .out_ready(or3), .diff(d3), .bo(bo3)
`ifdef CSA_SUB_OVF_EN
    , .ovf(ovf3)
`endif
  );

  csa_sub_pipe #(.N(8), .LO_W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
    .out_valid(ov8), .out_ready(or8), .diff(d8), .bo(bo8)
`ifdef CSA_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
    logic       ovf;
  } vec_t;

  vec_t tbl[10];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic bi);
    // {borrow, diff}: a 9-bit wrap of a-b-bin puts the borrow in bit 8
    return {1'b0, x} - {1'b0, y} - {8'd0, bi};
  endfunction

  logic [8:0] eq[$];
  logic [8:0] e9;
  int pops;

  initial begin
    tbl[0] = '{8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[1] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b1};
    tbl[8] = '{8'h3C, 8'h0F, 1'b1, 8'h2C, 1'b0, 1'b0};
    tbl[9] = '{8'h01, 8'h02, 1'b0, 8'hFF, 1'b1, 1'b0};

    rst = 1'b1;
    iv3 = 0; a3 = 0; b3 = 0; bin3 = 0; or3 = 1;
    iv8 = 0; a8 = 0; b8 = 0; bin8 = 0; or8 = 1;
    #1;
    chk("rst_ov8", ov8, 0);
    chk("rst_diff8", d8, 0);
    chk("rst_bo8", bo8, 0);
    chk("rst_ov3", ov3, 0);
`ifdef CSA_SUB_OVF_EN
    chk("rst_ovf8", ovf8, 0);
`endif
    step(); step();
    rst = 1'b0;
    #1;
    chk("rel_in_ready8", ir8, 1);
    chk("rel_in_ready3", ir3, 1);

    // ---- exhaustive N=3 stream: vector j-2 must appear at iteration j ----
    for (int j = 0; j < 130; j++) begin
      if (j < 128) begin
        iv3 = 1; a3 = 3'(j >> 4); b3 = 3'((j >> 1) & 7); bin3 = 1'(j & 1);
      end else begin
        iv3 = 0;
      end
      #1;
      if (j < 2) begin
        chk("sweep_latency_ov", ov3, 0);
      end else begin
        int i, ea, eb, ebin;
        logic [3:0] e4;
        i = j - 2; ea = i >> 4; eb = (i >> 1) & 7; ebin = i & 1;
        e4 = 4'(ea + (8 - eb) - ebin);
        chk("sweep_ov", ov3, 1);
        chk($sformatf("sweep_%0d", i), {~bo3, d3}, e4);
      end
      step();
    end
    iv3 = 0;
    step();
    chk("sweep_drained", ov3, 0);

    // ---- N=8 directed table, one vector at a time ----
    for (int k = 0; k < 10; k++) begin
      iv8 = 1; a8 = tbl[k].a; b8 = tbl[k].b; bin8 = tbl[k].bin;
      step();
      iv8 = 0;
      #1;
      chk("tbl_lat1_ov", ov8, 0);
      step();
      chk($sformatf("tbl%0d_ov", k), ov8, 1);
      chk($sformatf("tbl%0d_diff", k), d8, tbl[k].d);
      chk($sformatf("tbl%0d_bo", k), bo8, tbl[k].bo);
`ifdef CSA_SUB_OVF_EN
      chk($sformatf("tbl%0d_ovf", k), ovf8, tbl[k].ovf);
`endif
      step();
    end

    // ---- backpressure: 3 vectors, out_ready low ----
    or8 = 0;
    iv8 = 1; a8 = 8'h20; b8 = 8'h01; bin8 = 0; #1;
    chk("bp_ir_v1", ir8, 1);
    step();
    a8 = 8'h30; b8 = 8'h02; bin8 = 0; #1;
    chk("bp_ir_v2", ir8, 1);
    step();
    a8 = 8'h40; b8 = 8'h03; bin8 = 1; #1;
    for (int h = 0; h < 3; h++) begin
      chk("bp_ir_full", ir8, 0);
      chk("bp_ov_hold", ov8, 1);
      chk("bp_diff_hold", d8, 8'h1F);
      step();
    end
    or8 = 1; #1;
    chk("bp_ir_release", ir8, 1);
    step();
    iv8 = 0; #1;
    chk("bp_r2_ov", ov8, 1);
    chk("bp_r2", d8, 8'h2E);
    step();
    chk("bp_r3_ov", ov8, 1);
    chk("bp_r3", d8, 8'h3C);
    step();
    chk("bp_empty", ov8, 0);

    // ---- full pipe, simultaneous push and pop for 10 cycles ----
    or8 = 0;
    for (int k = 0; k < 2; k++) begin
      iv8 = 1; a8 = 8'(100 + 17 * k); b8 = 8'(40 * k); bin8 = 1'(k & 1); #1;
      if (ir8) eq.push_back(ref8(a8, b8, bin8));
      step();
    end
    or8 = 1;
    pops = 0;
    for (int c = 0; c < 10; c++) begin
      iv8 = 1; a8 = 8'(3 * c + 7); b8 = 8'(29 * c); bin8 = 1'(c & 1); #1;
      chk("pp_in_ready", ir8, 1);
      eq.push_back(ref8(a8, b8, bin8));
      if (ov8) begin
        e9 = eq.pop_front();
        chk($sformatf("pp_out_%0d", pops), {bo8, d8}, e9);
        pops++;
      end
      step();
    end
    chk("pp_pops", pops, 10);
    iv8 = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (ov8 && eq.size() > 0) begin
        e9 = eq.pop_front();
        chk("pp_drain", {bo8, d8}, e9);
      end
      step();
    end
    chk("pp_queue_empty", eq.size(), 0);

    // ---- reset with two items in flight ----
    or8 = 0;
    iv8 = 1; a8 = 8'h11; b8 = 8'h01; bin8 = 0; step();
    a8 = 8'h22; b8 = 8'h02; step();
    iv8 = 0;
    chk("rs_pre_ov", ov8, 1);
    rst = 1; #1;
    chk("rs_ov_now", ov8, 0);
    chk("rs_diff_now", d8, 0);
    step();
    rst = 0; or8 = 1;
    step();
    chk("rs_no_spur1", ov8, 0);
    step();
    chk("rs_no_spur2", ov8, 0);
    iv8 = 1; a8 = 8'h55; b8 = 8'h11; bin8 = 0; #1;
    chk("rs_ir", ir8, 1);
    step();
    iv8 = 0; #1;
    chk("rs_lat1", ov8, 0);
    step();
    chk("rs_lat2_ov", ov8, 1);
    chk("rs_lat2_diff", d8, 8'h44);
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
